// File: rtl/addsub_pkg.sv
// Shared types and elaboration helpers for the multi-cycle adder-subtractor.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEF_WIDTH  = 20;
    localparam int DEF_CHUNK  = 4;
    localparam int DEF_NCHUNK = DEF_WIDTH / DEF_CHUNK;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((32'sd1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/addsub_if.sv
// Operand/result handshake bundle for addsub_multicycle.
interface addsub_if #(
    parameter int WIDTH = 20
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, carry, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, carry, ovf, zero
    );
endinterface

// File: rtl/addsub_chunk.sv
// Combinational CHUNK-bit ripple adder slice; also exposes the carry into its top bit.
module addsub_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             c_msb_in
);
    logic [CHUNK:0] c_s;

    // Bit-serial ripple through the slice
    always_comb begin
        c_s    = {(CHUNK+1){1'b0}};
        s      = {CHUNK{1'b0}};
        c_s[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            s[i]     = a[i] ^ b[i] ^ c_s[i];
            c_s[i+1] = (a[i] & b[i]) | (c_s[i] & (a[i] ^ b[i]));
        end
    end

    assign cout     = c_s[CHUNK];
    assign c_msb_in = c_s[CHUNK-1];

endmodule

// File: rtl/addsub_multicycle.sv
// Multi-cycle add/subtract: CHUNK bits per clock, LSB first, carry held between chunks.
// Build option: define ADDSUB_SAT_EN to saturate the result on signed overflow.
module addsub_multicycle
    import addsub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input logic     clk,
    input logic     rst_n,
    addsub_if.slave bus
);
    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int IDXW   = (clog2(NCHUNK) < 1) ? 1 : clog2(NCHUNK);

    if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_param_check
        $error("addsub_multicycle: WIDTH must be >= 2 and a multiple of CHUNK");
    end

    state_e            state_r;
    state_e            state_s;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic              cy_r;
    logic [IDXW-1:0]   idx_r;
    logic [CHUNK-1:0]  s_s;
    logic              cout_s;
    logic              cmsb_s;
    logic              last_s;
    logic              ovf_s;
    logic              zero_s;
    logic [WIDTH-1:0]  word_s;
    logic [WIDTH-1:0]  res_s;
    logic [WIDTH-1:0]  out_sum_r;
    logic              out_carry_r;
    logic              out_ovf_r;
    logic              out_zero_r;

    // Operands shift right each RUN cycle, so the active chunk is always the low slice
    addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a        (a_r[CHUNK-1:0]),
        .b        (b_r[CHUNK-1:0]),
        .cin      (cy_r),
        .s        (s_s),
        .cout     (cout_s),
        .c_msb_in (cmsb_s)
    );

    assign last_s = (idx_r == IDXW'(NCHUNK - 1));
    assign ovf_s  = cmsb_s ^ cout_s;

    if (NCHUNK == 1) begin : g_single
        assign word_s = s_s;
    end else begin : g_multi
        logic [WIDTH-CHUNK-1:0] acc_r;

        // Completed low chunks; each new chunk enters at the top and drifts down
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                acc_r <= {(WIDTH-CHUNK){1'b0}};
            end else if (state_r == RUN) begin
                acc_r <= word_s[WIDTH-1:CHUNK];
            end
        end

        assign word_s = {s_s, acc_r};
    end

    // Final result, optionally clamped; on the last chunk a_r[CHUNK-1] is A's original MSB
    always_comb begin
        res_s = word_s;
`ifdef ADDSUB_SAT_EN
        if (ovf_s) begin
            res_s = a_r[CHUNK-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            res_s = word_s;
        end
`endif
    end

    assign zero_s = (res_s == {WIDTH{1'b0}});

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.in_valid) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Operand latch and chunk sequencing; subtract is A + ~B + 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r   <= {WIDTH{1'b0}};
            b_r   <= {WIDTH{1'b0}};
            cy_r  <= 1'b0;
            idx_r <= {IDXW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_r   <= bus.a;
                        b_r   <= bus.b ^ {WIDTH{bus.sub}};
                        cy_r  <= bus.sub;
                        idx_r <= {IDXW{1'b0}};
                    end
                end
                RUN: begin
                    a_r   <= a_r >> CHUNK;
                    b_r   <= b_r >> CHUNK;
                    cy_r  <= cout_s;
                    idx_r <= idx_r + IDXW'(1);
                end
                default: begin
                    a_r <= a_r;
                end
            endcase
        end
    end

    // Result and flags captured on the last chunk only, held until the next result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sum_r   <= {WIDTH{1'b0}};
            out_carry_r <= 1'b0;
            out_ovf_r   <= 1'b0;
            out_zero_r  <= 1'b0;
        end else if (state_r == RUN && last_s) begin
            out_sum_r   <= res_s;
            out_carry_r <= cout_s;
            out_ovf_r   <= ovf_s;
            out_zero_r  <= zero_s;
        end
    end

    assign bus.in_ready  = (state_r == IDLE);
    assign bus.out_valid = (state_r == DONE);
    assign bus.sum       = out_sum_r;
    assign bus.carry     = out_carry_r;
    assign bus.ovf       = out_ovf_r;
    assign bus.zero      = out_zero_r;

endmodule
